// File: rtl/wfg_mem_arbiter.sv
// Waveform SRAM read-port arbiter: round-robin, or fixed priority when
// WFG_MEM_ARB_FIXED_PRIO_EN is defined; tagged pipelined read returns.
module wfg_mem_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic             io_wbs_clk,
  input  logic             io_wbs_rst,
  input  logic             en_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*AW-1:0] addr_i,
  output logic [NREQ-1:0]  ack_o,
  output logic [NREQ-1:0]  rvalid_o,
  output logic [DW-1:0]    rdata_o,
  output logic             busy_o,
  output logic             csb1,
  output logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    dout1
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           gnt;
  logic [IW-1:0]             gidx;
  logic                      accept;
  logic                      csb_q;
  logic [AW-1:0]             addr_q;
  logic [MEM_LAT:0]          tv_q;
  logic [MEM_LAT:0][IW-1:0]  ti_q;
  logic [NREQ-1:0]           rvalid_q;
  logic [DW-1:0]             rdata_q;

`ifdef WFG_MEM_ARB_FIXED_PRIO_EN
  // Descending scan: the last hit, i.e. the lowest index, wins.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        gidx   = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] last_q;
  logic [IW-1:0] ix;

  // Scan offsets far-to-near so the nearest requester after last_q wins.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    ix   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      ix = IW'((int'(last_q) + k) % NREQ);
      if (req_i[ix]) begin
        gnt     = '0;
        gnt[ix] = 1'b1;
        gidx    = ix;
      end
    end
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      last_q <= IW'(NREQ - 1);
    end else if (accept) begin
      last_q <= gidx;
    end
  end
`endif

  assign ack_o  = en_i ? gnt : '0;
  assign accept = |ack_o;

  // Tag pipeline advances every cycle; the last stage is rvalid_q itself.
  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      csb_q    <= 1'b1;
      addr_q   <= '0;
      tv_q     <= '0;
      ti_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      csb_q <= ~accept;
      if (accept) begin
        addr_q <= addr_i[gidx*AW +: AW];
      end
      tv_q     <= {tv_q[MEM_LAT-1:0], accept};
      ti_q     <= {ti_q[MEM_LAT-1:0], gidx};
      rvalid_q <= tv_q[MEM_LAT] ? (NREQ'(1) << ti_q[MEM_LAT]) : '0;
      if (tv_q[MEM_LAT]) begin
        rdata_q <= dout1;
      end
    end
  end

  assign csb1     = csb_q;
  assign addr1    = addr_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = (|tv_q) | (|rvalid_q);

endmodule

// File: tb/tb_wfg_mem_arbiter.sv
// Directed bench for wfg_mem_arbiter with a 1-cycle SRAM read model.
module tb_wfg_mem_arbiter;

`ifdef WFG_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        io_wbs_rst;
  logic        en_i;
  logic [3:0]  req_i;
  logic [39:0] addr_i;
  logic [3:0]  ack_o;
  logic [3:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        csb1;
  logic [9:0]  addr1;
  logic [31:0] dout1;

  logic [9:0]  taddr [4];
  logic [3:0]  pv [3];
  logic [9:0]  pa [3];
  logic [9:0]  exp_a1;
  logic [31:0] exp_rd;
  int          n_cmp;
  int          n_bad;

  wfg_mem_arbiter #(
    .NREQ(4), .AW(10), .DW(32), .MEM_LAT(1)
  ) dut (
    .io_wbs_clk (clk),
    .io_wbs_rst (io_wbs_rst),
    .en_i       (en_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .ack_o      (ack_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .busy_o     (busy_o),
    .csb1       (csb1),
    .addr1      (addr1),
    .dout1      (dout1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mf(input logic [9:0] a);
    return 32'hDA7A0000 | {22'd0, a ^ 10'h2AA};
  endfunction

  // SRAM: address sampled at an edge, data valid for the next cycle.
  always_ff @(posedge clk) begin
    if (!csb1) dout1 <= mf(addr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic [3:0] rq, input logic [3:0] ea);
    logic [9:0] na;
    @(negedge clk);
    io_wbs_rst = r;
    en_i       = e;
    req_i      = rq;
    addr_i     = {taddr[3], taddr[2], taddr[1], taddr[0]};
    #1;
    if (pv[0] != 4'd0) exp_a1 = pa[0];
    if (pv[2] != 4'd0) exp_rd = mf(pa[2]);
    chk("ack", 32'(ack_o), 32'(ea));
    chk("csb1", 32'(csb1), 32'(pv[0] == 4'd0));
    chk("addr1", 32'(addr1), 32'(exp_a1));
    chk("rvalid", 32'(rvalid_o), 32'(pv[2]));
    chk("rdata", rdata_o, exp_rd);
    chk("busy", 32'(busy_o), 32'((pv[0] | pv[1] | pv[2]) != 4'd0));
    na = '0;
    for (int i = 0; i < 4; i++) if (ea[i]) na = taddr[i];
    pv[2] = pv[1]; pa[2] = pa[1];
    pv[1] = pv[0]; pa[1] = pa[0];
    pv[0] = ea;    pa[0] = na;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        pv[i] = '0;
        pa[i] = '0;
      end
      exp_a1 = '0;
      exp_rd = '0;
    end
  endtask

  initial begin
    clk = 1'b0;
    io_wbs_rst = 1'b1;
    en_i = 1'b0;
    req_i = '0;
    addr_i = '0;
    n_cmp = 0;
    n_bad = 0;
    exp_a1 = '0;
    exp_rd = '0;
    for (int i = 0; i < 4; i++) taddr[i] = '0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = '0;
      pa[i] = '0;
    end
    repeat (2) @(posedge clk);

    // Reset state, then single read of address 5
    cyc(0, 1, 4'b0000, 4'b0000);
    taddr[0] = 10'h005;
    cyc(0, 1, 4'b0001, 4'b0001);
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);
    cyc(1, 1, 4'b0000, 4'b0000);

    // All four requesting for 8 cycles
    for (int i = 0; i < 4; i++) taddr[i] = 10'h100 + 10'(i);
    for (int k = 0; k < 8; k++)
      cyc(0, 1, 4'b1111, FIXED ? 4'b0001 : 4'(1 << (k % 4)));
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);

    // Single requester streaming 16 addresses
    for (int k = 0; k < 16; k++) begin
      taddr[2] = 10'(k);
      cyc(0, 1, 4'b0100, 4'b0100);
    end
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);

    // Enable dropped with two reads in flight
    taddr[0] = 10'h3F0;
    taddr[1] = 10'h3F1;
    cyc(0, 1, 4'b0001, 4'b0001);
    cyc(0, 1, 4'b0010, 4'b0010);
    cyc(0, 0, 4'b1111, 4'b0000);
    repeat (3) cyc(0, 0, 4'b0000, 4'b0000);
    cyc(0, 1, 4'b1111, FIXED ? 4'b0001 : 4'b0100);
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);

    // Reset one cycle after an accept drops that read
    taddr[0] = 10'h2AA;
    cyc(0, 1, 4'b0001, 4'b0001);
    cyc(1, 1, 4'b0000, 4'b0000);
    cyc(0, 1, 4'b0000, 4'b0000);
    cyc(0, 1, 4'b0000, 4'b0000);
    cyc(0, 1, 4'b0000, 4'b0000);
    taddr[1] = 10'h011;
    taddr[3] = 10'h033;
    cyc(0, 1, 4'b1010, 4'b0010);
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);

    // Two requesters held: alternate, or requester 0 only
    cyc(0, 1, 4'b0011, 4'b0001);
    cyc(0, 1, 4'b0011, FIXED ? 4'b0001 : 4'b0010);
    cyc(0, 1, 4'b0011, 4'b0001);
    cyc(0, 1, 4'b0011, FIXED ? 4'b0001 : 4'b0010);
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
